// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm
// Multi-cycle control unit for the FRiscV RV32I core. Sequences fetch,
// decode, execute, memory access and writeback around the decoder,
// instruction register, ALU and register file, and drives the instruction
// and data memory req/gnt/rvalid handshakes plus the datapath strobes/selects.
//
// Build option: define MEM_TIMEOUT_EN to bound every memory wait to
// TIMEOUT_CYCLES stalled cycles; an expired wait traps with bus_err_out set.
// Without it the FSM waits indefinitely and bus_err_out is tied low.
module core_ctrl_fsm #(
  parameter int ARCH           = 32,  // datapath width, kept for interface consistency
  parameter int TIMEOUT_CYCLES = 16   // stalled-cycle limit, MEM_TIMEOUT_EN builds only
) (
  input  logic       clk_in,
  input  logic       rst_in,
  // decoder / branch comparator
  input  logic [6:0] op_code_in,
  input  logic       branch_taken_in,
  // instruction memory handshake
  output logic       imem_req_out,
  input  logic       imem_gnt_in,
  input  logic       imem_rvalid_in,
  // data memory handshake
  output logic       dmem_req_out,
  output logic       dmem_we_out,
  input  logic       dmem_gnt_in,
  input  logic       dmem_rvalid_in,
  // datapath controls
  output logic       ir_en_out,
  output logic       pc_en_out,
  output logic [1:0] pc_sel_out,
  output logic       alu_src_b_out,
  output logic       rf_we_out,
  output logic [1:0] wb_sel_out,
  // status
  output logic       instr_retired_out,
  output logic       illegal_instr_out,
  output logic       bus_err_out,
  output logic [2:0] state_out
);

  // RV32I major opcodes (same values as the friscv_pkg constants).
  localparam logic [6:0] OP_REG       = 7'b0110011;  // R-type ALU
  localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;  // I-type ALU
  localparam logic [6:0] OP_IMM_LOAD  = 7'b0000011;  // loads
  localparam logic [6:0] OP_IMM_JUMP  = 7'b1100111;  // JALR
  localparam logic [6:0] OP_STORE     = 7'b0100011;  // stores
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;  // conditional branches
  localparam logic [6:0] OP_U_L_LOAD  = 7'b0110111;  // LUI
  localparam logic [6:0] OP_JUMP      = 7'b1101111;  // JAL

  // PC source select
  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_IMM   = 2'b01;
  localparam logic [1:0] PC_SEL_ALU   = 2'b10;

  // Register-file writeback source select
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  // The 8-bit wait counter cannot represent a limit above 255, and a zero
  // limit would trap on the first stall; an out-of-range configuration
  // elaborates this marker scope so it is visible in the hierarchy.
  generate
    if (ARCH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
    end
  endgenerate

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    EXECUTE    = 3'd3,
    MEM_REQ    = 3'd4,
    MEM_WAIT   = 3'd5,
    WRITEBACK  = 3'd6,
    TRAP       = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic       illegal_q, illegal_d;

  // Unmasked control values; every output is forced low while rst_in is high.
  logic       imem_req_c;
  logic       dmem_req_c;
  logic       dmem_we_c;
  logic       ir_en_c;
  logic       pc_en_c;
  logic [1:0] pc_sel_c;
  logic       alu_src_b_c;
  logic       rf_we_c;
  logic [1:0] wb_sel_c;
  logic       retired_c;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       bus_err_q, bus_err_d;
  logic       stalled;
`endif

  // Opcodes the core implements; anything else traps.
  function automatic logic op_is_legal(input logic [6:0] op);
    case (op)
      OP_REG, OP_IMM_ARITH, OP_IMM_LOAD, OP_IMM_JUMP,
      OP_STORE, OP_BRANCH, OP_U_L_LOAD, OP_JUMP: op_is_legal = 1'b1;
      default:                                   op_is_legal = 1'b0;
    endcase
  endfunction

  // Instructions whose second ALU operand is the immediate.
  function automatic logic op_uses_imm(input logic [6:0] op);
    case (op)
      OP_IMM_ARITH, OP_IMM_LOAD, OP_IMM_JUMP, OP_STORE: op_uses_imm = 1'b1;
      default:                                          op_uses_imm = 1'b0;
    endcase
  endfunction

  // Writeback source: ALU result, load data, link address or the U immediate.
  function automatic logic [1:0] op_wb_sel(input logic [6:0] op);
    case (op)
      OP_IMM_LOAD:          op_wb_sel = WB_SEL_MEM;
      OP_JUMP, OP_IMM_JUMP: op_wb_sel = WB_SEL_PC4;
      OP_U_L_LOAD:          op_wb_sel = WB_SEL_IMM;
      default:              op_wb_sel = WB_SEL_ALU;
    endcase
  endfunction

  // Next-PC source applied at writeback: JAL is PC-relative, JALR uses the ALU.
  function automatic logic [1:0] op_wb_pc_sel(input logic [6:0] op);
    case (op)
      OP_JUMP:     op_wb_pc_sel = PC_SEL_IMM;
      OP_IMM_JUMP: op_wb_pc_sel = PC_SEL_ALU;
      default:     op_wb_pc_sel = PC_SEL_PLUS4;
    endcase
  endfunction

`ifdef MEM_TIMEOUT_EN
  // A cycle counts as stalled when the FSM sits in a wait state and the
  // response it is waiting for did not arrive in that same cycle.
  assign stalled = ((state_q == FETCH_REQ)  && !imem_gnt_in)    ||
                   ((state_q == FETCH_WAIT) && !imem_rvalid_in) ||
                   ((state_q == MEM_REQ)    && !dmem_gnt_in)    ||
                   ((state_q == MEM_WAIT)   && !dmem_rvalid_in);
`endif

  // State, latched opcode and sticky illegal flag; reset abandons any transfer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= FETCH_REQ;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Wait-state counter and sticky bus error flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end
`endif

  // Next-state and control decode; all strobes default low.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    illegal_d   = illegal_q;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    ir_en_c     = 1'b0;
    pc_en_c     = 1'b0;
    pc_sel_c    = PC_SEL_PLUS4;
    alu_src_b_c = 1'b0;
    rf_we_c     = 1'b0;
    wb_sel_c    = WB_SEL_ALU;
    retired_c   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    bus_err_d   = bus_err_q;
`endif

    // Operand and writeback selects stay stable from EXECUTE to WRITEBACK so
    // the datapath sees no glitches while a memory access is outstanding.
    if (state_q == EXECUTE || state_q == MEM_REQ ||
        state_q == MEM_WAIT || state_q == WRITEBACK) begin
      alu_src_b_c = op_uses_imm(op_q);
      wb_sel_c    = op_wb_sel(op_q);
    end

    case (state_q)
      FETCH_REQ: begin
        imem_req_c = 1'b1;
        if (imem_gnt_in) begin
          state_d = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        if (imem_rvalid_in) begin
          ir_en_c = 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        op_d = op_code_in;
        if (op_is_legal(op_code_in)) begin
          state_d = EXECUTE;
        end else begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end
      end

      EXECUTE: begin
        if (op_q == OP_BRANCH) begin
          // Branches resolve here: the PC moves and the instruction retires.
          pc_en_c   = 1'b1;
          pc_sel_c  = branch_taken_in ? PC_SEL_IMM : PC_SEL_PLUS4;
          retired_c = 1'b1;
          state_d   = FETCH_REQ;
        end else if (op_q == OP_IMM_LOAD || op_q == OP_STORE) begin
          state_d = MEM_REQ;
        end else begin
          state_d = WRITEBACK;
        end
      end

      MEM_REQ: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (op_q == OP_STORE);
        if (dmem_gnt_in) begin
          state_d = MEM_WAIT;
        end
      end

      MEM_WAIT: begin
        if (dmem_rvalid_in) begin
          if (op_q == OP_STORE) begin
            // Store acknowledge completes the instruction; nothing to write back.
            pc_en_c   = 1'b1;
            pc_sel_c  = PC_SEL_PLUS4;
            retired_c = 1'b1;
            state_d   = FETCH_REQ;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end

      WRITEBACK: begin
        // rd = x0 is filtered inside the register file.
        rf_we_c   = 1'b1;
        pc_en_c   = 1'b1;
        pc_sel_c  = op_wb_pc_sel(op_q);
        retired_c = 1'b1;
        state_d   = FETCH_REQ;
      end

      TRAP: begin
        // Terminal until reset; all strobes remain low.
      end

      default: begin
        state_d = TRAP;
      end
    endcase

`ifdef MEM_TIMEOUT_EN
    // A response in the limit cycle is not a stall, so it wins over the error.
    if (stalled) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (int'(wait_cnt_d) >= TIMEOUT_CYCLES) begin
        state_d   = TRAP;
        bus_err_d = 1'b1;
      end
    end
    // Every new request starts with a fresh budget.
    if (state_d != state_q && (state_d == FETCH_REQ || state_d == MEM_REQ)) begin
      wait_cnt_d = '0;
    end
`endif
  end

  assign imem_req_out      = imem_req_c & ~rst_in;
  assign dmem_req_out      = dmem_req_c & ~rst_in;
  assign dmem_we_out       = dmem_we_c & ~rst_in;
  assign ir_en_out         = ir_en_c & ~rst_in;
  assign pc_en_out         = pc_en_c & ~rst_in;
  assign pc_sel_out        = rst_in ? 2'b00 : pc_sel_c;
  assign alu_src_b_out     = alu_src_b_c & ~rst_in;
  assign rf_we_out         = rf_we_c & ~rst_in;
  assign wb_sel_out        = rst_in ? 2'b00 : wb_sel_c;
  assign instr_retired_out = retired_c & ~rst_in;
  assign illegal_instr_out = illegal_q & ~rst_in;
  assign state_out         = rst_in ? 3'd0 : state_q;

`ifdef MEM_TIMEOUT_EN
  assign bus_err_out = bus_err_q & ~rst_in;
`else
  assign bus_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Testbench for core_ctrl_fsm. Each scenario queues an expected cycle-by-cycle
// trace built from the instruction-level rules (phases of fetch, decode,
// execute, memory and writeback with chosen handshake delays), replays the
// inputs and compares every output each cycle. Unused inputs are randomised.
module tb_core_ctrl_fsm;
  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int MAXD = 1;
`else
  localparam int MAXD = 3;
`endif

  localparam logic [6:0] OP_REG       = 7'b0110011;
  localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OP_IMM_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM_JUMP  = 7'b1100111;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_U_L_LOAD  = 7'b0110111;
  localparam logic [6:0] OP_JUMP      = 7'b1101111;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [6:0] op_code_in = '0;
  logic       branch_taken_in = 1'b0;
  logic       imem_gnt_in = 1'b0, imem_rvalid_in = 1'b0;
  logic       dmem_gnt_in = 1'b0, dmem_rvalid_in = 1'b0;
  logic       imem_req_out, dmem_req_out, dmem_we_out, ir_en_out, pc_en_out;
  logic [1:0] pc_sel_out, wb_sel_out;
  logic       alu_src_b_out, rf_we_out, instr_retired_out;
  logic       illegal_instr_out, bus_err_out;
  logic [2:0] state_out;

  core_ctrl_fsm #(.ARCH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .op_code_in(op_code_in), .branch_taken_in(branch_taken_in),
    .imem_req_out(imem_req_out), .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_gnt_in(dmem_gnt_in), .dmem_rvalid_in(dmem_rvalid_in),
    .ir_en_out(ir_en_out), .pc_en_out(pc_en_out), .pc_sel_out(pc_sel_out),
    .alu_src_b_out(alu_src_b_out), .rf_we_out(rf_we_out), .wb_sel_out(wb_sel_out),
    .instr_retired_out(instr_retired_out), .illegal_instr_out(illegal_instr_out),
    .bus_err_out(bus_err_out), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  // One cycle: inputs to drive, then the outputs required in that cycle.
  typedef struct packed {
    logic       rst, ig, ir, dg, dr, bt;
    logic [6:0] op;
    logic [2:0] st;
    logic       imem_req, dmem_req, dmem_we, ir_en, pc_en;
    logic [1:0] pc_sel;
    logic       alu_b, rf_we;
    logic [1:0] wb_sel;
    logic       ret, ill, berr;
  } cyc_t;

  cyc_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_REG, OP_IMM_ARITH, OP_IMM_LOAD, OP_IMM_JUMP,
                      OP_STORE, OP_BRANCH, OP_U_L_LOAD, OP_JUMP};
  endfunction

  // Blank cycle in a given state: outputs idle, irrelevant inputs random.
  function automatic cyc_t mk(input logic [2:0] st);
    cyc_t c = '0;
    c.st = st;
    c.op = 7'($urandom);
    c.bt = 1'($urandom);
    if (st != 3'd4 && st != 3'd5) begin
      c.dg = 1'($urandom);
      c.dr = 1'($urandom);
    end
    if (st != 3'd1) c.ir = 1'($urandom);
    if (st >= 3'd2) c.ig = 1'($urandom);
    return c;
  endfunction

  function automatic logic [16:0] exp_vec(input cyc_t c);
    return {c.st, c.imem_req, c.dmem_req, c.dmem_we, c.ir_en, c.pc_en, c.pc_sel,
            c.alu_b, c.rf_we, c.wb_sel, c.ret, c.ill, c.berr};
  endfunction

  function automatic logic [16:0] observe();
    return {state_out, imem_req_out, dmem_req_out, dmem_we_out, ir_en_out, pc_en_out,
            pc_sel_out, alu_src_b_out, rf_we_out, wb_sel_out, instr_retired_out,
            illegal_instr_out, bus_err_out};
  endfunction

  task automatic model_reset(input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = '0;
      c.rst = 1'b1;
      c.ig = 1'($urandom); c.ir = 1'($urandom);
      c.dg = 1'($urandom); c.dr = 1'($urandom);
      c.op = 7'($urandom); c.bt = 1'($urandom);
      exp_q.push_back(c);
    end
  endtask

  task automatic model_trap(input int n, input logic ill, input logic berr);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = mk(3'd7); c.ill = ill; c.berr = berr;
      exp_q.push_back(c);
    end
  endtask

  // One instruction: gd/rd = stalled cycles before imem gnt/rvalid,
  // mgd/mrd = the same for the data side.
  task automatic model_instr(input logic [6:0] op, input logic bt, input int gd,
                             input int rd, input int mgd, input int mrd);
    cyc_t c;
    logic imm, is_ld, is_st;
    logic [1:0] wb, pcs;
    imm   = op inside {OP_IMM_ARITH, OP_IMM_LOAD, OP_IMM_JUMP, OP_STORE};
    is_ld = (op == OP_IMM_LOAD);
    is_st = (op == OP_STORE);
    wb  = is_ld ? 2'b01 : (op == OP_JUMP || op == OP_IMM_JUMP) ? 2'b10 :
          (op == OP_U_L_LOAD) ? 2'b11 : 2'b00;
    pcs = (op == OP_JUMP) ? 2'b01 : (op == OP_IMM_JUMP) ? 2'b10 : 2'b00;
    for (int k = 0; k <= gd; k++) begin
      c = mk(3'd0); c.imem_req = 1'b1; c.ig = (k == gd); exp_q.push_back(c);
    end
    for (int k = 0; k <= rd; k++) begin
      c = mk(3'd1); c.ir = (k == rd); c.ir_en = (k == rd); exp_q.push_back(c);
    end
    c = mk(3'd2); c.op = op; exp_q.push_back(c);
    if (!is_legal(op)) return;
    c = mk(3'd3); c.alu_b = imm; c.wb_sel = wb;
    if (op == OP_BRANCH) begin
      c.bt = bt; c.pc_en = 1'b1; c.pc_sel = {1'b0, bt}; c.ret = 1'b1;
      exp_q.push_back(c);
      return;
    end
    exp_q.push_back(c);
    if (is_ld || is_st) begin
      for (int k = 0; k <= mgd; k++) begin
        c = mk(3'd4); c.dmem_req = 1'b1; c.dmem_we = is_st; c.dg = (k == mgd);
        c.alu_b = imm; c.wb_sel = wb; exp_q.push_back(c);
      end
      for (int k = 0; k <= mrd; k++) begin
        c = mk(3'd5); c.dr = (k == mrd); c.alu_b = imm; c.wb_sel = wb;
        if (is_st && k == mrd) begin c.pc_en = 1'b1; c.ret = 1'b1; end
        exp_q.push_back(c);
      end
      if (is_st) return;
    end
    c = mk(3'd6); c.rf_we = 1'b1; c.pc_en = 1'b1; c.ret = 1'b1; c.pc_sel = pcs;
    c.alu_b = imm; c.wb_sel = wb; exp_q.push_back(c);
  endtask

  // Drive one cycle's inputs just after the edge; outputs are read at negedge.
  task automatic apply(input cyc_t c);
    @(posedge clk_in); #1;
    rst_in = c.rst; imem_gnt_in = c.ig; imem_rvalid_in = c.ir;
    dmem_gnt_in = c.dg; dmem_rvalid_in = c.dr;
    op_code_in = c.op; branch_taken_in = c.bt;
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    cyc_t c; int n = 0;
    model_reset(3);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      n++;
    end
  endtask

  task automatic test_reg_add();
    cyc_t c; int n = 0; int ret_cnt = 0;
    model_instr(OP_REG, 1'b0, 0, 0, 0, 0);
    c = mk(3'd0); c.imem_req = 1'b1; c.ig = 1'b0; exp_q.push_back(c);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL reg_add cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      ret_cnt += int'(instr_retired_out); n++;
    end
    checks++;
    if (ret_cnt !== 1) begin
      failures++; $display("FAIL reg_add_retire_count got=%0d exp=1", ret_cnt);
    end
  endtask

  task automatic test_branch();
    cyc_t c; int n = 0; int we_cnt = 0;
    model_instr(OP_BRANCH, 1'b1, 0, 0, 0, 0);
    model_instr(OP_BRANCH, 1'b0, 0, 0, 0, 0);
    model_instr(OP_BRANCH, 1'($urandom), 1, 2, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL branch cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      we_cnt += int'(rf_we_out); n++;
    end
    checks++;
    if (we_cnt !== 0) begin
      failures++; $display("FAIL branch_rf_we got=%0d exp=0", we_cnt);
    end
  endtask

  task automatic test_load_store();
    cyc_t c; int n = 0; int req_cnt = 0; int we_cnt = 0; int rf_cnt = 0;
    model_instr(OP_IMM_LOAD, 1'b0, 0, 0, 3, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL load cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      req_cnt += int'(dmem_req_out); we_cnt += int'(dmem_we_out); n++;
    end
    checks++;
    if (req_cnt !== 4 || we_cnt !== 0) begin
      failures++; $display("FAIL load_req_cycles got=%0d/%0d exp=4/0", req_cnt, we_cnt);
    end
    n = 0; req_cnt = 0; we_cnt = 0;
    model_instr(OP_STORE, 1'b0, 0, 0, 3, 1);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL store cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      we_cnt += int'(dmem_we_out); rf_cnt += int'(rf_we_out); n++;
    end
    checks++;
    if (we_cnt !== 4 || rf_cnt !== 0) begin
      failures++; $display("FAIL store_we_rf got=%0d/%0d exp=4/0", we_cnt, rf_cnt);
    end
  endtask

  task automatic test_jumps();
    cyc_t c; int n = 0;
    model_instr(OP_IMM_JUMP, 1'b0, 0, 0, 0, 0);
    model_instr(OP_JUMP, 1'b0, 0, 1, 0, 0);
    model_instr(OP_U_L_LOAD, 1'b0, 1, 0, 0, 0);
    model_instr(OP_IMM_ARITH, 1'b0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL jumps cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c; int n = 0; logic [6:0] bad;
    bad = 7'h7F;
    for (int t = 0; t < 2; t++) begin
      model_instr(bad, 1'b0, 0, 0, 0, 0);
      model_trap(6, 1'b1, 1'b0);
      model_reset(2);
      c = mk(3'd0); c.imem_req = 1'b1; c.ig = 1'b0; exp_q.push_back(c);
      do bad = 7'($urandom); while (is_legal(bad));
    end
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL illegal cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      n++;
    end
  endtask

  task automatic test_abort();
    cyc_t c; int n = 0; int keep;
    keep = exp_q.size() + 5;
    model_instr(OP_IMM_LOAD, 1'b0, 0, 0, 2, 0);
    while (exp_q.size() > keep) void'(exp_q.pop_back());
    model_reset(2);
    model_instr(OP_REG, 1'b0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL abort cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    cyc_t c; int n = 0;
`ifdef MEM_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      c = mk(3'd0); c.imem_req = 1'b1; c.ig = 1'b0; exp_q.push_back(c);
    end
    model_trap(4, 1'b0, 1'b1);
    model_reset(2);
    c = mk(3'd0); c.imem_req = 1'b1; c.ig = 1'b1; exp_q.push_back(c);
    for (int k = 0; k < TO; k++) begin
      c = mk(3'd1); c.ir = 1'b0; exp_q.push_back(c);
    end
    model_trap(4, 1'b0, 1'b1);
    model_reset(2);
`else
    model_instr(OP_REG, 1'b0, 0, 100, 0, 0);
`endif
    model_instr(OP_REG, 1'b0, 0, TO - 1, 0, 0);
    model_instr(OP_IMM_LOAD, 1'b0, 0, 0, 0, TO - 1);
    model_instr(OP_STORE, 1'b0, TO - 1, 0, TO - 1, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      n++;
    end
  endtask

  task automatic test_random();
    cyc_t c; int n = 0; int ret_cnt = 0;
    logic [6:0] ops [8];
    ops = '{OP_REG, OP_IMM_ARITH, OP_IMM_LOAD, OP_IMM_JUMP,
            OP_STORE, OP_BRANCH, OP_U_L_LOAD, OP_JUMP};
    for (int i = 0; i < 40; i++) begin
      model_instr(ops[$urandom_range(0, 7)], 1'($urandom),
                  $urandom_range(0, MAXD), $urandom_range(0, MAXD),
                  $urandom_range(0, MAXD), $urandom_range(0, MAXD));
    end
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observe() !== exp_vec(c)) begin
        failures++;
        $display("FAIL random cyc=%0d got=%05h exp=%05h", n, observe(), exp_vec(c));
      end
      ret_cnt += int'(instr_retired_out); n++;
    end
    checks++;
    if (ret_cnt !== 40) begin
      failures++; $display("FAIL random_retire_count got=%0d exp=40", ret_cnt);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reg_add();
    test_branch();
    test_load_store();
    test_jumps();
    test_illegal();
    test_abort();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
